// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit shift-add multiplier / restoring divider with HI/LO and register-file write-back
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] data
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op_r;
  logic [AW-1:0] dest_r;
  logic sa, sb, dz;
  logic [WIDTH-1:0] a, b, ma, mb;
  logic [$clog2(WIDTH)-1:0] cnt;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH:0] mul_sum, t;
  logic [WIDTH+1:0] d;
  logic ge;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  always_comb begin
    ma = (op[0] && opa[WIDTH-1]) ? -opa : opa;
    mb = (op[0] && opb[WIDTH-1]) ? -opb : opb;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    t = acc[2*WIDTH-1:WIDTH-1];
    d = {1'b0, t} - {2'b0, b};
    ge = ~d[WIDTH+1];
    step = op_r[1] ? {(ge ? d[WIDTH-1:0] : t[WIDTH-1:0]), acc[WIDTH-2:0], ge}
                   : {mul_sum, acc[WIDTH-1:1]};
    // sa/sb are only set for signed ops, so unsigned results pass through unchanged
    prod = (sa ^ sb) ? -acc : acc;
    fix_hi = op_r[1] ? (sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_r[1] ? ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
  end
  always_comb begin
    state_n = (state == IDLE) ? (start ? CALC : IDLE)
            : (state == CALC) ? (dz ? DONE : (&cnt ? FIX : CALC))
            : (state == FIX)  ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op_r <= '0;
      dest_r <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
      div_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_r <= op;
        dest_r <= dest;
        sa <= op[0] & opa[WIDTH-1];
        sb <= op[0] & opb[WIDTH-1];
        dz <= op[1] && opb == '0;
        a <= ma;
        b <= mb;
        cnt <= '0;
        acc <= op[1] ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb};
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= step;
      end
      // divide by zero reports the dividend exactly as presented
      if (state == CALC && dz) begin
        hi <= sa ? -a : a;
        lo <= '1;
        div_zero <= 1'b1;
      end
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
        div_zero <= 1'b0;
      end
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign we = done && dest_r != '0;
  assign waddr = dest_r;
  assign data = lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random ops against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] op = 0;
  logic [31:0] opa = 0, opb = 0;
  logic [4:0] dest = 0;
  logic busy, done, div_zero, we;
  logic [31:0] hi, lo, data;
  logic [4:0] waddr;
  int n_tests = 0, n_fail = 0;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .dest(dest),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero),
    .we(we), .waddr(waddr), .data(data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p, q, r;
    logic [63:0] u;
    case (o)
      2'd0: begin
        u = {32'b0, x} * {32'b0, y};
        return {1'b0, u};
      end
      2'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return {1'b0, p[63:0]};
      end
      2'd2: return (y == 0) ? {1'b1, x, 32'hFFFFFFFF} : {1'b0, x % y, x / y};
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] dd, input bit disturb);
    logic [64:0] e;
    int n, lat;
    e = model(o, x, y);
    lat = (o[1] && y == 0) ? 1 : 33;
    start = 1; op = o; opa = x; opb = y; dest = dd;
    @(posedge clk); #1;
    start = 0; opa = $urandom; opb = $urandom; op = 2'($urandom); dest = 5'($urandom);
    check("busy_rise", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      start = disturb && n == 9;
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    check("latency", n, lat);
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    check("div_zero", div_zero, e[64]);
    check("we", we, dd != 0);
    check("waddr", waddr, dd);
    check("data", data, e[31:0]);
    @(posedge clk); #1;
    check("idle_after", {busy, done, we}, 0);
  endtask
  initial begin
    logic [31:0] x, y;
    logic [1:0] o;
    #12;
    check("rst_outs", {busy, done, we, div_zero, waddr}, 0);
    check("rst_data", {hi, lo, data}, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0);
    do_op(2'd1, -32'sd3, 32'd5, 5'd7, 0);
    do_op(2'd2, 32'd100, 32'd7, 5'd1, 0);
    do_op(2'd3, -32'sd7, 32'd2, 5'd2, 0);
    do_op(2'd3, 32'd7, -32'sd2, 5'd2, 0);
    do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, 5'd4, 0);
    do_op(2'd2, 32'h1234, 32'd0, 5'd5, 0);
    do_op(2'd0, 32'd2, 32'd3, 5'd5, 0);
    do_op(2'd3, -32'sd9, 32'd0, 5'd6, 0);
    do_op(2'd1, 32'h12345678, -32'sd1000, 5'd0, 1);
    start = 1; op = 2'd1; opa = 32'd1234; opb = -32'sd77; dest = 5'd9;
    @(posedge clk); #1 start = 0;
    repeat (15) @(posedge clk);
    #1 rst = 0;
    #1 check("abort_outs", {busy, done, we, div_zero}, 0);
    check("abort_hilo", {hi, lo}, 0);
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 check("abort_quiet", {busy, done, we}, 0);
    do_op(2'd0, 32'd6, 32'd7, 5'd8, 0);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      do_op(o, x, y, 5'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
